// File: rtl/tdc_cal_sequencer_pkg.sv
// Shared definitions for the TDC calibration sequencer: state encoding,
// default code geometry and the accumulator width derivation.
package tdc_cal_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ARM    = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } cal_state_t;

    localparam int CODE_W_DEF = 10;
    localparam int N_LOG2_DEF = 3;
    localparam int TIMER_W    = 8;

    // Accumulator holds 2^n_log2 full-scale codes without wrapping.
    function automatic int acc_width(input int code_w, input int n_log2);
        return code_w + n_log2;
    endfunction

endpackage

// File: rtl/tdc_cal_timer.sv
// Loadable 8-bit down-counter with zero flag; times both the settle gap
// and the per-sample conversion timeout.
module tdc_cal_timer
    import tdc_cal_sequencer_pkg::*;
(
    input  logic               clk40,
    input  logic               resetn,
    input  logic               load,
    input  logic               dec,
    input  logic [TIMER_W-1:0] load_value,
    output logic               zero
);

    logic [TIMER_W-1:0] count_reg;

    always_ff @(posedge clk40) begin
        if (!resetn) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - TIMER_W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/tdc_cal_sequencer.sv
// Calibration sequencer: sweeps 2^N_LOG2 test-mode TDC conversions,
// averages the returned codes and flags conversions that never return.
module tdc_cal_sequencer
    import tdc_cal_sequencer_pkg::*;
#(
    parameter int CODE_W  = CODE_W_DEF,
    parameter int N_LOG2  = N_LOG2_DEF,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk40,
    input  logic              resetn,
    input  logic              start_cal,
    input  logic              cal_abort,
    input  logic              tdc_valid,
    input  logic [CODE_W-1:0] tdc_code,
    output logic              tdc_enable,
    output logic              tdc_testMode,
    output logic              tdc_autoReset,
    output logic              cal_busy,
    output logic [CODE_W-1:0] cal_mean,
    output logic              cal_done,
    output logic              timeout_err,
    output logic [N_LOG2-1:0] sample_idx
);

    localparam int ACC_W = acc_width(CODE_W, N_LOG2);
    localparam logic [TIMER_W-1:0] SETTLE_LD  = TIMER_W'(SETTLE - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LD = TIMER_W'(TIMEOUT - 1);
    localparam logic [N_LOG2-1:0]  IDX_LAST   = {N_LOG2{1'b1}};

    cal_state_t state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [N_LOG2-1:0]  idx_reg, idx_next;
    logic [CODE_W-1:0]  mean_reg;
    logic               enable_reg, test_mode_reg, auto_reset_reg;
    logic               busy_reg, done_reg, err_reg;
    logic               err_clr;
    logic               tmr_load, tmr_dec, tmr_zero;
    logic [TIMER_W-1:0] tmr_load_value;

    tdc_cal_timer u_timer (
        .clk40      (clk40),
        .resetn     (resetn),
        .load       (tmr_load),
        .dec        (tmr_dec),
        .load_value (tmr_load_value),
        .zero       (tmr_zero)
    );

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        idx_next       = idx_reg;
        err_clr        = 1'b0;
        tmr_load       = 1'b0;
        tmr_dec        = 1'b0;
        tmr_load_value = '0;
        case (state_reg)
            ST_IDLE: begin
                if (start_cal) begin
                    acc_next   = '0;
                    idx_next   = '0;
                    err_clr    = 1'b1;
                    state_next = ST_RST;
                end
            end
            ST_RST: begin
                tmr_load       = 1'b1;
                tmr_load_value = SETTLE_LD;
                state_next     = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    tmr_load       = 1'b1;
                    tmr_load_value = TIMEOUT_LD;
                    state_next     = ST_ARM;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_ARM: begin
                // A valid on the final timeout cycle still counts as a sample.
                if (tdc_valid) begin
                    acc_next = acc_reg + ACC_W'(tdc_code);
                    if (idx_reg == IDX_LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx_reg + N_LOG2'(1);
                        state_next = ST_RST;
                    end
                end else if (tmr_zero) begin
                    state_next = ST_ERR;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // Abort overrides every transition and freezes the partial data.
        if (cal_abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
            acc_next   = acc_reg;
            idx_next   = idx_reg;
            tmr_load   = 1'b0;
            tmr_dec    = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk40) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            acc_reg        <= '0;
            idx_reg        <= '0;
            mean_reg       <= '0;
            enable_reg     <= 1'b0;
            test_mode_reg  <= 1'b0;
            auto_reset_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            idx_reg        <= idx_next;
            enable_reg     <= (state_next == ST_RST) || (state_next == ST_SETTLE)
                              || (state_next == ST_ARM);
            test_mode_reg  <= (state_next == ST_ARM);
            auto_reset_reg <= (state_next == ST_RST);
            busy_reg       <= (state_next != ST_IDLE);
            done_reg       <= (state_next == ST_DONE) || (state_next == ST_ERR);
            if (state_next == ST_DONE) begin
                mean_reg <= acc_next[ACC_W-1:N_LOG2];
            end
            if (state_next == ST_ERR) begin
                err_reg <= 1'b1;
            end else if (err_clr) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign tdc_enable    = enable_reg;
    assign tdc_testMode  = test_mode_reg;
    assign tdc_autoReset = auto_reset_reg;
    assign cal_busy      = busy_reg;
    assign cal_mean      = mean_reg;
    assign cal_done      = done_reg;
    assign timeout_err   = err_reg;
    assign sample_idx    = idx_reg;

endmodule
